baudrate_gen_frac: RTL and testbench

//  Parametrised UART baud tick generator with a runtime-programmable integer+fractional divisor.

---
 rtl/baudrate_gen_frac_if.sv | 26 ++
 rtl/baudrate_gen_frac.sv | 135 +++++++++++++
 tb/tb_baudrate_gen_frac.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/baudrate_gen_frac_if.sv
// Bus bundle for the fractional baud tick generator: divisor programming,
// run control and the tick/status outputs.
interface baudrate_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();
  logic              enable;
  logic              div_load;
  logic [DIV_W-1:0]  div_int_in;
  logic [FRAC_W-1:0] div_frac_in;
  logic              resync;
  logic              tick_os;
  logic              tick_bit;
  logic              div_pending;
  logic              div_err;

  modport master (
    output enable, div_load, div_int_in, div_frac_in, resync,
    input  tick_os, tick_bit, div_pending, div_err
  );

  modport slave (
    input  enable, div_load, div_int_in, div_frac_in, resync,
    output tick_os, tick_bit, div_pending, div_err
  );
endinterface

// File: rtl/baudrate_gen_frac.sv
// Fractional UART baud tick generator.
// A down-counter reloads with D-1 (plus one on fractional carry) at every wrap,
// giving tick_os periods of D or D+1 clocks that average D + F/2^FRAC_W.
// Every OVERSAMPLE-th tick_os also raises tick_bit.
// New divisors wait in a pending slot and are only applied at a period
// boundary (wrap, resync, or while disabled) so no period is ever truncated.
module baudrate_gen_frac #(
  parameter int DIV_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RESET_DIV_INT  = 162,
  parameter int RESET_DIV_FRAC = 12
) (
  input logic               clock_i,
  input logic               reset_i,
  baudrate_gen_frac_if.slave bus
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [DIV_W-1:0]  div_int_p_q, div_int_p_d;
  logic [FRAC_W-1:0] div_frac_p_q, div_frac_p_d;
  logic              pend_q, pend_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_bit_q, tick_bit_d;
  logic              err_q, err_d;

  logic [DIV_W-1:0]  d_sel;
  logic [FRAC_W-1:0] f_sel;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;
  logic              apply_pend;

  // Next-state logic: resync beats disable beats wrap; divisor load is
  // evaluated last so a same-cycle load always lands in the pending slot.
  always_comb begin
    d_sel   = pend_q ? div_int_p_q  : div_int_q;
    f_sel   = pend_q ? div_frac_p_q : div_frac_q;
    acc_sum = {1'b0, acc_q} + {1'b0, f_sel};
    wrap    = (cnt_q == '0);

    cnt_d        = cnt_q;
    acc_d        = acc_q;
    os_cnt_d     = os_cnt_q;
    div_int_d    = div_int_q;
    div_frac_d   = div_frac_q;
    div_int_p_d  = div_int_p_q;
    div_frac_p_d = div_frac_p_q;
    pend_d       = pend_q;
    tick_os_d    = 1'b0;
    tick_bit_d   = 1'b0;
    err_d        = 1'b0;
    apply_pend   = 1'b0;

    if (bus.resync) begin
      cnt_d      = d_sel - DIV_W'(1);
      acc_d      = '0;
      os_cnt_d   = '0;
      apply_pend = 1'b1;
    end else if (!bus.enable) begin
      // Idle is a safe boundary: take a pending divisor now and start clean.
      if (pend_q) begin
        cnt_d      = d_sel - DIV_W'(1);
        acc_d      = '0;
        os_cnt_d   = '0;
        apply_pend = 1'b1;
      end
    end else if (wrap) begin
      tick_os_d  = 1'b1;
      tick_bit_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
      acc_d      = acc_sum[FRAC_W-1:0];
      cnt_d      = d_sel - DIV_W'(1) + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};
      os_cnt_d   = os_cnt_q + OS_W'(1);
      apply_pend = 1'b1;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    if (apply_pend && pend_q) begin
      div_int_d  = div_int_p_q;
      div_frac_d = div_frac_p_q;
      pend_d     = 1'b0;
    end

    if (bus.div_load) begin
      if (bus.div_int_in != '0) begin
        div_int_p_d  = bus.div_int_in;
        div_frac_p_d = bus.div_frac_in;
        pend_d       = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q        <= DIV_W'(RESET_DIV_INT - 1);
      acc_q        <= '0;
      os_cnt_q     <= '0;
      div_int_q    <= DIV_W'(RESET_DIV_INT);
      div_frac_q   <= FRAC_W'(RESET_DIV_FRAC);
      div_int_p_q  <= '0;
      div_frac_p_q <= '0;
      pend_q       <= 1'b0;
      tick_os_q    <= 1'b0;
      tick_bit_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      os_cnt_q     <= os_cnt_d;
      div_int_q    <= div_int_d;
      div_frac_q   <= div_frac_d;
      div_int_p_q  <= div_int_p_d;
      div_frac_p_q <= div_frac_p_d;
      pend_q       <= pend_d;
      tick_os_q    <= tick_os_d;
      tick_bit_q   <= tick_bit_d;
      err_q        <= err_d;
    end
  end

  assign bus.tick_os     = tick_os_q;
  assign bus.tick_bit    = tick_bit_q;
  assign bus.div_pending = pend_q;
  assign bus.div_err     = err_q;

endmodule

// File: tb/tb_baudrate_gen_frac.sv
// Bench for baudrate_gen_frac. The reference model schedules ticks on an
// absolute clock-edge timeline: each tick books the edge of the next one
// (now + D + carry), disabled cycles push that edge out, resync/reset rebook it.
module tb_baudrate_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;
  localparam int RST_I  = 162;
  localparam int RST_F  = 12;
  localparam int FSCALE = 1 << FRAC_W;

  logic clk = 1'b0;
  logic rst;

  baudrate_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus_if ();

  baudrate_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
    .RESET_DIV_INT(RST_I), .RESET_DIV_FRAC(RST_F)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  longint edge_n = 0;
  longint next_tick = 0;
  int m_int, m_frac, p_int, p_frac, m_acc, m_ticks;
  bit m_pend;
  bit e_os, e_bit, e_err, e_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit ld, input int di,
                            input int df, input bit rs);
    int d, f;
    bit apply;
    edge_n++;
    e_os = 0; e_bit = 0; e_err = 0;
    if (r) begin
      m_int = RST_I; m_frac = RST_F; m_pend = 0; p_int = 0; p_frac = 0;
      m_acc = 0; m_ticks = 0;
      next_tick = edge_n + RST_I;
      e_pend = 0;
      return;
    end
    d = m_pend ? p_int : m_int;
    f = m_pend ? p_frac : m_frac;
    apply = 0;
    if (rs) begin
      next_tick = edge_n + d; m_acc = 0; m_ticks = 0; apply = 1;
    end else if (!en) begin
      if (m_pend) begin
        next_tick = edge_n + d; m_acc = 0; m_ticks = 0; apply = 1;
      end else begin
        next_tick++;
      end
    end else if (edge_n == next_tick) begin
      e_os  = 1;
      e_bit = ((m_ticks % OS) == OS - 1);
      m_ticks++;
      next_tick = edge_n + d + (m_acc + f) / FSCALE;
      m_acc = (m_acc + f) % FSCALE;
      apply = 1;
    end
    if (apply && m_pend) begin
      m_int = p_int; m_frac = p_frac; m_pend = 0;
    end
    if (ld) begin
      if (di != 0) begin
        p_int = di; p_frac = df; m_pend = 1;
      end else begin
        e_err = 1;
      end
    end
    e_pend = m_pend;
  endtask

  task automatic cyc(input bit r, input bit en, input bit ld, input int di,
                     input int df, input bit rs);
    rst                = r;
    bus_if.enable      = en;
    bus_if.div_load    = ld;
    bus_if.div_int_in  = DIV_W'(di);
    bus_if.div_frac_in = FRAC_W'(df);
    bus_if.resync      = rs;
    @(posedge clk);
    model_step(r, en, ld, di, df, rs);
    #1;
    chk("tick_os",     32'(bus_if.tick_os),     32'(e_os));
    chk("tick_bit",    32'(bus_if.tick_bit),    32'(e_bit));
    chk("div_pending", 32'(bus_if.div_pending), 32'(e_pend));
    chk("div_err",     32'(bus_if.div_err),     32'(e_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  int os_seen;

  initial begin
    rst = 1'b1;
    bus_if.enable = 0; bus_if.div_load = 0; bus_if.div_int_in = '0;
    bus_if.div_frac_in = '0; bus_if.resync = 0;

    // reset and default 162.75 divisor
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    os_seen = 0;
    for (int i = 0; i < 2604; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      os_seen += int'(bus_if.tick_os);
    end
    chk("t2_os_count_2604", 32'(os_seen), 32'd16);

    // 163/0 divisor, mid-period loads, illegal load, resync, enable gap
    cyc(0, 1, 1, 163, 0, 0);
    run(2700);
    run(113);
    cyc(0, 1, 1, 100, 0, 0);
    run(400);
    cyc(0, 1, 1, 0, 5, 0);
    run(200);
    cyc(0, 1, 1, 163, 0, 0);
    run(300);
    cyc(0, 1, 0, 0, 0, 1);
    run(2700);
    run(50);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 0);
    run(400);
    cyc(1, 1, 0, 0, 0, 0);
    run(200);

    // randomized traffic with small divisors so bit ticks are frequent
    cyc(0, 1, 1, 2, 7, 0);
    for (int i = 0; i < 12000; i++) begin
      bit en, ld, rs, r;
      int di, df;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 199) == 0);
      rs = ($urandom_range(0, 399) == 0);
      r  = ($urandom_range(0, 2999) == 0);
      di = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      df = int'($urandom_range(0, FSCALE - 1));
      cyc(r, en, ld, di, df, rs);
      if (r) cyc(0, 1, 1, int'($urandom_range(1, 6)), int'($urandom_range(0, FSCALE - 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
